cpu_debug_scanner: RTL and testbench

Reader side of the CPU debug display port. Drives `rf_addr`/`mem_addr` into the pipeline CPU's display inputs, samples `rf_data`/`mem_data`, and emits one tagged 32-bit word per register or memory word on a valid/ready stream for a UART or LCD sink. One scan dumps all 32 GPRs and then a configurable window of data memory, without stalling or touching the CPU pipeline.

---
 rtl/cpu_debug_scanner.sv | 155 +++++++++++++++
 tb/tb_cpu_debug_scanner.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_debug_scanner.sv
// cpu_debug_scanner: walks the CPU debug display port (32 GPRs, then a window
// of data memory) and streams each sampled word with a tag on valid/ready.
module cpu_debug_scanner #(
    parameter logic [31:0] MEM_BASE  = 32'h0000_0000,
    parameter int unsigned MEM_WORDS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [4:0]  rf_addr,
    output logic [31:0] mem_addr,
    input  logic [31:0] rf_data,
    input  logic [31:0] mem_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [7:0]  out_tag,
    output logic        busy,
    output logic        done
);

    localparam int unsigned IDX_W      = 7;
    localparam int unsigned LAST_RF_I  = 31;
    localparam int unsigned LAST_MEM_I = (MEM_WORDS == 0) ? 0 : MEM_WORDS - 1;
    localparam logic [IDX_W-1:0] LAST_RF  = IDX_W'(LAST_RF_I);
    localparam logic [IDX_W-1:0] LAST_MEM = IDX_W'(LAST_MEM_I);
    localparam logic HAS_MEM = (MEM_WORDS != 0);

    localparam logic PH_RF  = 1'b0;
    localparam logic PH_MEM = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SET  = 3'd1,
        S_WAIT = 3'd2,
        S_OUT  = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_phase;
    logic             w_phase_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [31:0]      w_mem_addr_nxt;
    logic             w_handshake;

    logic [4:0]       r_rf_addr;
    logic [31:0]      r_mem_addr;
    logic             r_out_valid;
    logic [31:0]      r_out_data;
    logic [7:0]       r_out_tag;
    logic             r_busy;
    logic             r_done;

    assign w_handshake    = r_out_valid & out_ready;
    // Memory byte address of the next item; wraps naturally at 2^32.
    assign w_mem_addr_nxt = MEM_BASE + 32'({w_idx_nxt, 2'b00});

    // State, phase and item index registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_phase <= PH_RF;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Next-state logic: walk registers, then the memory window.
    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_idx_nxt   = r_idx;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_SET;
                    w_phase_nxt = PH_RF;
                    w_idx_nxt   = '0;
                end
            end
            S_SET:  w_state_nxt = S_WAIT;
            S_WAIT: w_state_nxt = S_OUT;
            S_OUT: begin
                if (w_handshake) begin
                    if (r_phase == PH_RF) begin
                        if (r_idx != LAST_RF) begin
                            w_idx_nxt   = r_idx + IDX_W'(1);
                            w_state_nxt = S_SET;
                        end else if (HAS_MEM) begin
                            w_phase_nxt = PH_MEM;
                            w_idx_nxt   = '0;
                            w_state_nxt = S_SET;
                        end else begin
                            w_state_nxt = S_FIN;
                        end
                    end else begin
                        if (r_idx != LAST_MEM) begin
                            w_idx_nxt   = r_idx + IDX_W'(1);
                            w_state_nxt = S_SET;
                        end else begin
                            w_state_nxt = S_FIN;
                        end
                    end
                end
            end
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Registered outputs: addresses on entry to SET, sample at end of WAIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rf_addr   <= '0;
            r_mem_addr  <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_tag   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != S_IDLE);
            r_done <= (w_state_nxt == S_FIN);
            if (w_state_nxt == S_SET) begin
                if (w_phase_nxt == PH_MEM) begin
                    r_mem_addr <= w_mem_addr_nxt;
                end else begin
                    r_rf_addr <= w_idx_nxt[4:0];
                end
            end
            if (r_state == S_WAIT) begin
                r_out_valid <= 1'b1;
                r_out_data  <= (r_phase == PH_MEM) ? mem_data : rf_data;
                r_out_tag   <= {r_phase, r_idx};
            end else if (w_handshake) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign rf_addr   = r_rf_addr;
    assign mem_addr  = r_mem_addr;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_tag   = r_out_tag;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_cpu_debug_scanner.sv
// Testbench for cpu_debug_scanner: three instances (no memory window,
// window at 0x40, window wrapping past 0xFFFF_FFFC) driven by directed scans.
module tb_cpu_debug_scanner;

    localparam int unsigned NI = 3;

    logic        clk;
    logic        reset;
    logic        start     [NI];
    logic        out_ready [NI];
    logic [4:0]  rf_addr   [NI];
    logic [31:0] mem_addr  [NI];
    logic        out_valid [NI];
    logic [31:0] out_data  [NI];
    logic [7:0]  out_tag   [NI];
    logic        busy      [NI];
    logic        done      [NI];

    int n_checks;
    int n_pass;

    // Results of the most recent scan.
    logic [31:0] q_data[$];
    logic [7:0]  q_tag[$];
    logic [31:0] q_maddr[$];
    int          first_valid;
    int          done_cyc;
    int          done_cnt;
    int          stall_seen;
    logic        busy_c1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DUTs with a combinational regfile model (r[i] = i*0x11111111) and a
    // synchronous-read memory model (word = 0xA0000000 | address).
    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam logic [31:0] BASE  = (g == 0) ? 32'h0000_0000 :
                                        (g == 1) ? 32'h0000_0040 : 32'hFFFF_FFF8;
        localparam int unsigned WORDS = (g == 0) ? 0 : (g == 1) ? 4 : 3;
        logic [31:0] rf_d;
        logic [31:0] mem_q;
        assign rf_d = 32'(rf_addr[g]) * 32'h1111_1111;
        always @(posedge clk) mem_q <= 32'hA000_0000 | mem_addr[g];
        cpu_debug_scanner #(.MEM_BASE(BASE), .MEM_WORDS(WORDS)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .start     (start[g]),
            .rf_addr   (rf_addr[g]),
            .mem_addr  (mem_addr[g]),
            .rf_data   (rf_d),
            .mem_data  (mem_q),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_data  (out_data[g]),
            .out_tag   (out_tag[g]),
            .busy      (busy[g]),
            .done      (done[g])
        );
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One scan on instance k. Optional: stall word stall_word for stall_len
    // valid cycles, extra start at restart_cyc, start on the done cycle,
    // reset during the OUT of word reset_word.
    task automatic run_scan(input int k, input int stall_word, input int stall_len,
                            input int restart_cyc, input bit start_on_done,
                            input int reset_word);
        int          stall_cnt;
        int          post;
        bit          stop;
        bit          aborted;
        bit          rel;
        logic [31:0] hold_d;
        logic [7:0]  hold_t;
        logic [31:0] prev_ma;
        q_data.delete();
        q_tag.delete();
        q_maddr.delete();
        first_valid = -1;
        done_cyc    = -1;
        done_cnt    = 0;
        busy_c1     = 1'b0;
        stall_cnt   = 0;
        post        = 0;
        stop        = 1'b0;
        aborted     = 1'b0;
        rel         = 1'b0;
        hold_d      = '0;
        hold_t      = '0;
        prev_ma     = mem_addr[k];
        @(posedge clk); #1;
        start[k]     = 1'b1;
        out_ready[k] = 1'b1;
        for (int cyc = 1; cyc < 400 && !stop; cyc++) begin
            @(posedge clk); #1;
            start[k] = 1'b0;
            if (cyc == restart_cyc) start[k] = 1'b1;
            if (done[k]) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    if (start_on_done) start[k] = 1'b1;
                end
            end
            if (cyc == 1) busy_c1 = busy[k];
            if (mem_addr[k] != prev_ma) begin
                q_maddr.push_back(mem_addr[k]);
                prev_ma = mem_addr[k];
            end
            if (out_valid[k] && first_valid < 0) first_valid = cyc;
            if (!aborted && reset_word >= 0 && q_data.size() == reset_word && out_valid[k]) begin
                reset = 1'b1;
                #1;
                check("rst_valid", 32'(out_valid[k]), 32'd0);
                check("rst_busy", 32'(busy[k]), 32'd0);
                aborted = 1'b1;
                rel     = 1'b1;
            end
            out_ready[k] = !(q_data.size() == stall_word && stall_cnt < stall_len);
            @(negedge clk);
            if (rel) begin
                reset = 1'b0;
                rel   = 1'b0;
            end
            if (!out_ready[k] && stall_cnt > 0 && stall_cnt < stall_len)
                check("stall_valid", 32'(out_valid[k]), 32'd1);
            if (out_valid[k] && !out_ready[k]) begin
                if (stall_cnt == 0) begin
                    hold_d = out_data[k];
                    hold_t = out_tag[k];
                end else begin
                    check("stall_data", out_data[k], hold_d);
                    check("stall_tag", 32'(out_tag[k]), 32'(hold_t));
                end
                stall_cnt++;
            end else if (out_valid[k] && out_ready[k]) begin
                q_data.push_back(out_data[k]);
                q_tag.push_back(out_tag[k]);
            end
            if (done_cyc >= 0 || aborted) post++;
            if (post >= 8) stop = 1'b1;
        end
        start[k]     = 1'b0;
        out_ready[k] = 1'b1;
        stall_seen   = stall_cnt;
    endtask

    // The 32 register words: tag i, data i*0x11111111.
    task automatic check_rf(input string pfx);
        for (int i = 0; i < 32; i++) begin
            check({pfx, "_rf_data"}, q_data[i], 32'(i) * 32'h1111_1111);
            check({pfx, "_rf_tag"}, 32'(q_tag[i]), 32'(i));
        end
    endtask

    logic [31:0] exp_c_data [4];
    logic [31:0] exp_c_addr [4];
    logic [31:0] exp_d_data [3];
    logic [31:0] exp_d_addr [3];

    initial begin
        n_checks = 0;
        n_pass   = 0;
        exp_c_data = '{32'hA000_0040, 32'hA000_0044, 32'hA000_0048, 32'hA000_004C};
        exp_c_addr = '{32'h0000_0040, 32'h0000_0044, 32'h0000_0048, 32'h0000_004C};
        exp_d_data = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'hA000_0000};
        exp_d_addr = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        reset = 1'b1;
        for (int i = 0; i < NI; i++) begin
            start[i]     = 1'b0;
            out_ready[i] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_rf_addr", 32'(rf_addr[0]), 32'd0);
        check("rst_mem_addr", mem_addr[0], 32'd0);
        check("rst_out_valid", 32'(out_valid[0]), 32'd0);
        check("rst_out_data", out_data[0], 32'd0);
        check("rst_out_tag", 32'(out_tag[0]), 32'd0);
        check("rst_busy", 32'(busy[0]), 32'd0);
        check("rst_done", 32'(done[0]), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Registers only, extra starts mid-scan and on the done cycle.
        run_scan(0, -1, 0, 20, 1'b1, -1);
        check("a_first_valid", 32'(first_valid), 32'd3);
        check("a_done_cyc", 32'(done_cyc), 32'd97);
        check("a_done_cnt", 32'(done_cnt), 32'd1);
        check("a_words", 32'(q_data.size()), 32'd32);
        check("a_busy_c1", 32'(busy_c1), 32'd1);
        check("a_word5", q_data[5], 32'h5555_5555);
        check("a_busy_end", 32'(busy[0]), 32'd0);
        check_rf("a");

        // Sink stalls word 3 for 10 cycles.
        run_scan(0, 3, 10, -1, 1'b0, -1);
        check("b_words", 32'(q_data.size()), 32'd32);
        check("b_stall", 32'(stall_seen), 32'd10);
        check("b_done_cyc", 32'(done_cyc), 32'd107);
        check_rf("b");

        // Reset during the OUT of word 10, then a clean rescan.
        run_scan(0, -1, 0, -1, 1'b0, 10);
        check("r_done_cnt", 32'(done_cnt), 32'd0);
        check("r_words", 32'(q_data.size()), 32'd10);
        check("r_busy_end", 32'(busy[0]), 32'd0);
        run_scan(0, -1, 0, -1, 1'b0, -1);
        check("e_tag0", 32'(q_tag[0]), 32'h00);
        check("e_words", 32'(q_data.size()), 32'd32);
        check("e_done_cyc", 32'(done_cyc), 32'd97);
        check_rf("e");

        // Memory window of 4 words at 0x40.
        run_scan(1, -1, 0, -1, 1'b0, -1);
        check("c_words", 32'(q_data.size()), 32'd36);
        check("c_done_cyc", 32'(done_cyc), 32'd109);
        check("c_done_cnt", 32'(done_cnt), 32'd1);
        check_rf("c");
        check("c_maddr_n", 32'(q_maddr.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("c_mem_data", q_data[32+i], exp_c_data[i]);
            check("c_mem_tag", 32'(q_tag[32+i]), 32'h80 + 32'(i));
            check("c_mem_addr", q_maddr[i], exp_c_addr[i]);
        end

        // Memory window wrapping past the top of the address space.
        run_scan(2, -1, 0, -1, 1'b0, -1);
        check("d_words", 32'(q_data.size()), 32'd35);
        check("d_maddr_n", 32'(q_maddr.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check("d_mem_data", q_data[32+i], exp_d_data[i]);
            check("d_mem_tag", 32'(q_tag[32+i]), 32'h80 + 32'(i));
            check("d_mem_addr", q_maddr[i], exp_d_addr[i]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
